// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the fetch/decode pipeline registers.
package pipeline_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  localparam int unsigned DefPcWidth    = 8;
  localparam int unsigned DefInstrWidth = 32;
  localparam logic [31:0] DefNopInstr   = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_if_id_skid.sv
// IF/ID pipeline register with valid/ready handshake, one-entry skid buffer and flush.
// Optional performance counters are enabled by defining LATCH_IF_ID_PERF_EN.
module pipe_if_id_skid
  import pipeline_pkg::*;
#(
  parameter int unsigned           PC_WIDTH    = DefPcWidth,
  parameter int unsigned           INSTR_WIDTH = DefInstrWidth,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR  = INSTR_WIDTH'(DefNopInstr)
`ifdef LATCH_IF_ID_PERF_EN
  ,
  parameter int unsigned           CNT_WIDTH   = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_WIDTH-1:0]    next_pc,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_WIDTH-1:0]    next_pc_reg,
  output logic [INSTR_WIDTH-1:0] instruction_reg
`ifdef LATCH_IF_ID_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]   stall_cnt,
  output logic [CNT_WIDTH-1:0]   flush_cnt
`endif
);

  state_e                 state_q;
  logic [PC_WIDTH-1:0]    skid_pc_q;
  logic [INSTR_WIDTH-1:0] skid_instr_q;
  logic                   in_fire;
  logic                   out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StEmpty;
      out_valid       <= 1'b0;
      in_ready        <= 1'b1;
      next_pc_reg     <= '0;
      instruction_reg <= NOP_INSTR;
      skid_pc_q       <= '0;
      skid_instr_q    <= '0;
    end else if (flush) begin
      // Flush wins over any handshake; a same-cycle in_fire is dropped.
      state_q         <= StEmpty;
      out_valid       <= 1'b0;
      in_ready        <= 1'b1;
      next_pc_reg     <= '0;
      instruction_reg <= NOP_INSTR;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_q         <= StOne;
            out_valid       <= 1'b1;
            in_ready        <= 1'b1;
            next_pc_reg     <= next_pc;
            instruction_reg <= instruction;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            next_pc_reg     <= next_pc;
            instruction_reg <= instruction;
          end else if (in_fire) begin
            state_q      <= StTwo;
            in_ready     <= 1'b0;
            skid_pc_q    <= next_pc;
            skid_instr_q <= instruction;
          end else if (out_fire) begin
            state_q   <= StEmpty;
            out_valid <= 1'b0;
          end
        end
        StTwo: begin
          if (out_fire) begin
            state_q         <= StOne;
            in_ready        <= 1'b1;
            next_pc_reg     <= skid_pc_q;
            instruction_reg <= skid_instr_q;
          end
        end
        default: begin
          state_q   <= StEmpty;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef LATCH_IF_ID_PERF_EN
  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (in_valid & ~in_ready),
    .count (stall_cnt)
  );

  // out_valid mirrors state != StEmpty.
  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush & out_valid),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_if_id_skid.sv
// Self-checking bench for pipe_if_id_skid: vector table, hand sequences and a queue-based model.
module tb_pipe_if_id_skid;

  localparam logic [31:0] Nop = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  next_pc;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  next_pc_reg;
  logic [31:0] instruction_reg;
`ifdef LATCH_IF_ID_PERF_EN
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pipe_if_id_skid #(
    .PC_WIDTH    (8),
    .INSTR_WIDTH (32),
    .NOP_INSTR   (Nop)
`ifdef LATCH_IF_ID_PERF_EN
    ,
    .CNT_WIDTH   (4)
`endif
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .next_pc         (next_pc),
    .instruction     (instruction),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .next_pc_reg     (next_pc_reg),
    .instruction_reg (instruction_reg)
`ifdef LATCH_IF_ID_PERF_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a FIFO of at most two entries; the head is what decode sees.
  logic [39:0] m_q[$];
  logic [7:0]  m_pc;
  logic [31:0] m_instr;
  bit          m_in_ready;

  function automatic void model_reset();
    m_q.delete();
    m_pc       = '0;
    m_instr    = Nop;
    m_in_ready = 1'b1;
  endfunction

  function automatic void model_edge();
    bit inf;
    bit outf;
    inf  = in_valid && m_in_ready;
    outf = (m_q.size() > 0) && out_ready;
    if (flush) begin
      m_q.delete();
      m_pc    = '0;
      m_instr = Nop;
    end else begin
      if (outf) void'(m_q.pop_front());
      if (inf) m_q.push_back({next_pc, instruction});
      if (m_q.size() > 0) {m_pc, m_instr} = m_q[0];
    end
    m_in_ready = (m_q.size() < 2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_q.size() > 0));
    check({tag, ".in_ready"}, 64'(in_ready), 64'(m_in_ready));
    check({tag, ".next_pc_reg"}, 64'(next_pc_reg), 64'(m_pc));
    check({tag, ".instruction_reg"}, 64'(instruction_reg), 64'(m_instr));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit fl, input bit iv, input logic [7:0] pc, input logic [31:0] ins,
                       input bit ordy);
    flush       = fl;
    in_valid    = iv;
    next_pc     = pc;
    instruction = ins;
    out_ready   = ordy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          fl;
    bit          iv;
    logic [7:0]  pc;
    logic [31:0] ins;
    bit          ordy;
    bit          e_ov;
    bit          e_ir;
    logic [7:0]  e_pc;
    logic [31:0] e_ins;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{0, 1, 8'd1, 32'd2,  0, 1, 1, 8'd1, 32'd2};
    vecs[1]  = '{0, 0, 8'd0, 32'd0,  1, 0, 1, 8'd1, 32'd2};
    vecs[2]  = '{0, 1, 8'd3, 32'd6,  1, 1, 1, 8'd3, 32'd6};
    vecs[3]  = '{0, 1, 8'd4, 32'd8,  1, 1, 1, 8'd4, 32'd8};
    vecs[4]  = '{0, 1, 8'd5, 32'd10, 0, 1, 0, 8'd4, 32'd8};
    vecs[5]  = '{0, 1, 8'd6, 32'd12, 0, 1, 0, 8'd4, 32'd8};
    vecs[6]  = '{0, 1, 8'd6, 32'd12, 1, 1, 1, 8'd5, 32'd10};
    vecs[7]  = '{0, 1, 8'd6, 32'd12, 1, 1, 1, 8'd6, 32'd12};
    vecs[8]  = '{0, 0, 8'd0, 32'd0,  1, 0, 1, 8'd6, 32'd12};
    vecs[9]  = '{0, 1, 8'd7, 32'd14, 0, 1, 1, 8'd7, 32'd14};
    vecs[10] = '{0, 1, 8'd8, 32'd16, 0, 1, 0, 8'd7, 32'd14};
    vecs[11] = '{1, 1, 8'd9, 32'd18, 0, 0, 1, 8'd0, Nop};
    vecs[12] = '{0, 0, 8'd0, 32'd0,  1, 0, 1, 8'd0, Nop};

    rst_n = 1'b0;
    model_reset();
    drive(0, 1, 8'd1, 32'd2, 0);

    // Reset held with in_valid high.
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.next_pc_reg", 64'(next_pc_reg), 64'd0);
    check("rst.instruction_reg", 64'(instruction_reg), 64'(Nop));
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 8'd0, 32'd0, 0);
    @(posedge clk);
    #1;

    // Vector table.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ins, vecs[i].ordy);
      cycle();
      check($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      check($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
      check($sformatf("vec%0d.next_pc_reg", i), 64'(next_pc_reg), 64'(vecs[i].e_pc));
      check($sformatf("vec%0d.instruction_reg", i), 64'(instruction_reg), 64'(vecs[i].e_ins));
      check_model($sformatf("vecm%0d", i));
    end

    // Streaming pc 1..8 at full throughput.
    for (int pc = 1; pc <= 8; pc++) begin
      drive(0, 1, 8'(pc), 32'(2 * pc), 1);
      cycle();
      check($sformatf("stream%0d.pc", pc), 64'(next_pc_reg), 64'(pc));
      check($sformatf("stream%0d.instr", pc), 64'(instruction_reg), 64'(2 * pc));
      check($sformatf("stream%0d.in_ready", pc), 64'(in_ready), 64'd1);
      check($sformatf("stream%0d.out_valid", pc), 64'(out_valid), 64'd1);
    end
    drive(0, 0, 8'd0, 32'd0, 1);
    cycle();
    check_model("stream_drain");

    // Async reset between edges while holding two entries.
    drive(0, 1, 8'd2, 32'd4, 0);
    cycle();
    drive(0, 1, 8'd3, 32'd6, 0);
    cycle();
    check("pre_async.in_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async.out_valid", 64'(out_valid), 64'd0);
    check("async.in_ready", 64'(in_ready), 64'd1);
    check("async.next_pc_reg", 64'(next_pc_reg), 64'd0);
    check("async.instruction_reg", 64'(instruction_reg), 64'(Nop));
    drive(0, 0, 8'd0, 32'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_model("post_async");

    // Randomized traffic against the FIFO model; a stalled offer keeps its payload.
    for (int i = 0; i < 400; i++) begin
      bit stalled;
      stalled = in_valid && !m_in_ready && !flush;
      if (!stalled) begin
        in_valid    = ($urandom_range(0, 3) != 0);
        next_pc     = 8'($urandom);
        instruction = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cycle();
      check_model($sformatf("rnd%0d", i));
    end

`ifdef LATCH_IF_ID_PERF_EN
    drive(0, 0, 8'd0, 32'd0, 0);
    do_reset();
    check("perf.stall_rst", 64'(stall_cnt), 64'd0);
    check("perf.flush_rst", 64'(flush_cnt), 64'd0);
    drive(0, 1, 8'd1, 32'd2, 0);
    cycle();
    drive(0, 1, 8'd2, 32'd4, 0);
    cycle();
    repeat (20) cycle();
    check("perf.stall_sat", 64'(stall_cnt), 64'd15);
    drive(1, 0, 8'd0, 32'd0, 0);
    cycle();
    drive(0, 1, 8'd5, 32'd10, 0);
    cycle();
    drive(1, 0, 8'd0, 32'd0, 0);
    cycle();
    drive(1, 0, 8'd0, 32'd0, 0);
    cycle();
    check("perf.flush_cnt", 64'(flush_cnt), 64'd2);
    check_model("perf.model");
`endif

    drive(0, 0, 8'd0, 32'd0, 0);
    do_reset();
    check_model("final_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_if_id_skid.md
Name: pipe_if_id_skid

Overview:
Parametrised IF/ID pipeline register that replaces the plain clocked latch between fetch and decode. It adds:
- a valid/ready handshake on both sides;
- a one-entry skid buffer, so back-pressure from decode never drops a fetched instruction;
- a synchronous flush for taken branches and jumps.

It sits between the fetch stage (PC adder, instruction memory) and the decode stage (register file, control unit).

Parameters:
- PC_WIDTH, 8, width of next_pc.
- INSTR_WIDTH, 32, width of instruction.
- NOP_INSTR, 32'h0000_0000, instruction value presented on instruction_reg after reset or flush.
- CNT_WIDTH, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries (branch/jump resolved).
- in_valid  in  1  fetch presents a valid instruction.
- in_ready  out  1  latch can accept; registered.
- next_pc  in  PC_WIDTH  PC+1 from fetch.
- instruction  in  INSTR_WIDTH  fetched word.
- out_valid  out  1  next_pc_reg/instruction_reg hold a valid entry.
- out_ready  in  1  decode accepts the entry this cycle.
- next_pc_reg  out  PC_WIDTH  registered PC to decode.
- instruction_reg  out  INSTR_WIDTH  registered instruction to decode.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low, applied on rst_n.
- Reset values (asynchronous on rst_n low):
  - state EMPTY, out_valid 0, in_ready 1;
  - next_pc_reg 0, instruction_reg NOP_INSTR;
  - skid registers 0.
  - Reset may assert mid-transfer; all in-flight entries are discarded.
- Handshake events:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_valid may be high with in_ready low; the payload must be held stable until in_fire.
- State machine (registered state; main = output regs, skid = hidden regs):
  - EMPTY:
    - in_fire -> ONE, main <= input.
    - Otherwise stay EMPTY.
  - ONE:
    - in_fire & out_fire -> ONE, main <= input.
    - in_fire & !out_fire -> TWO, skid <= input.
    - !in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - TWO:
    - out_fire -> ONE, main <= skid.
    - Otherwise hold. in_fire is impossible here (in_ready 0).
- Output and ready derivation:
  - out_valid = (state != EMPTY), driven from a register.
  - in_ready registered; next value = (next_state != TWO).
- Latency and throughput:
  - Latency is 1 cycle from in_fire to out_valid when EMPTY.
  - Full throughput (1 per cycle) while out_ready stays high.
- Flush:
  - Highest priority over all handshakes.
  - Next state EMPTY, out_valid 0, in_ready 1.
  - instruction_reg <= NOP_INSTR, next_pc_reg <= 0.
  - Any in_fire in the same cycle is discarded.
  - out_fire in the flush cycle still counts as consumed by decode.
- Data hold: main registers change only on load or flush. When out_valid is 0 they hold their last value, never X.
- Ordering: FIFO order is preserved; skid contents always leave after main.

Optional Feature:
- Macro: LATCH_IF_ID_PERF_EN.
- When defined, two extra output ports exist:
  - stall_cnt (CNT_WIDTH): counts cycles with in_valid & !in_ready.
  - flush_cnt (CNT_WIDTH): counts cycles with flush high and state != EMPTY.
- Counter rules:
  - Both saturate at all-ones.
  - Both reset to 0 on rst_n.
  - Neither is cleared by flush.
- When undefined, the ports and logic are absent and datapath behaviour is identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - state encoding constants: EMPTY=2'd0, ONE=2'd1, TWO=2'd2;
  - NOP_INSTR default;
  - default PC_WIDTH/INSTR_WIDTH.
- One sub-module, sat_counter (parametrised width, inc, rst_n), instantiated twice under LATCH_IF_ID_PERF_EN.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, in_ready=1, instruction_reg=0, next_pc_reg=0. Release, present next_pc=1, instruction=2 -> one cycle later out_valid=1, next_pc_reg=1, instruction_reg=2.
- Streaming: out_ready=1, feed pc 1..8 with instr=2*pc back-to-back -> outputs 1..8 in order, one per cycle, in_ready never drops.
- Back-pressure: out_ready=0, feed pc=2/instr=4 then pc=3/instr=6 -> state TWO, in_ready=0, output stays 2/4. Raise out_ready -> 2/4 then 3/6 consumed, nothing lost or duplicated.
- Flush in TWO with a simultaneous in_valid (pc=9) -> next cycle out_valid=0, instruction_reg=NOP_INSTR, in_ready=1. pc=9 never appears.
- Async reset mid-stream, asserted between clock edges while in TWO -> outputs reset immediately without waiting for clk.
- With LATCH_IF_ID_PERF_EN, CNT_WIDTH=4: hold back-pressure for 20 stalled cycles -> stall_cnt saturates at 15. Two flushes of non-empty states -> flush_cnt=2.
